// File: rtl/vga_write_scheduler.sv
// vga_write_scheduler: burst-granting arbiter for the VGA pixel-write port (clear engine, letter renderer, cursor blinker); ports: CLOCK_50/reset, clr_start/clr_busy, l_* and b_* request/grant/write, registered x/y/color/writeEn, owner state
module vga_write_scheduler #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       clr_start,
  output logic       clr_busy,
  input  logic       l_req,
  output logic       l_gnt,
  input  logic [8:0] l_x,
  input  logic [8:0] l_y,
  input  logic [2:0] l_color,
  input  logic       l_en,
  input  logic       b_req,
  output logic       b_gnt,
  input  logic [8:0] b_x,
  input  logic [8:0] b_y,
  input  logic [2:0] b_color,
  input  logic       b_en,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic [2:0] color,
  output logic       writeEn,
  output logic [1:0] owner
);
  typedef enum logic [1:0] {IDLE, CLEAR, LETTER, BLINK} state_t;
  localparam logic [8:0] X_LAST = 9'(SCREEN_W - 1);
  localparam logic [8:0] Y_LAST = 9'(SCREEN_H - 1);
  state_t state, state_n, last_owner, last_n;
  logic clr_pending, pending_n;
  logic [8:0] x_cnt, y_cnt, x_cnt_n, y_cnt_n;
  logic l_inb, b_inb, x_wrap;
  assign l_inb = l_x < 9'(SCREEN_W) && l_y < 9'(SCREEN_H);
  assign b_inb = b_x < 9'(SCREEN_W) && b_y < 9'(SCREEN_H);
  assign x_wrap = x_cnt == X_LAST;
  assign l_gnt = state == LETTER;
  assign b_gnt = state == BLINK;
  assign clr_busy = clr_pending || state == CLEAR;
  assign owner = state;
  always_comb begin
    state_n = state;
    last_n = last_owner;
    pending_n = clr_pending || (clr_start && state != CLEAR);
    x_cnt_n = x_cnt;
    y_cnt_n = y_cnt;
    case (state)
      IDLE:
        // a same-cycle clr_start outranks waiting requesters
        if (clr_pending || clr_start) begin
          state_n = CLEAR;
          pending_n = 1'b0;
          x_cnt_n = '0;
          y_cnt_n = '0;
        end else if (l_req && b_req) state_n = last_owner == LETTER ? BLINK : LETTER;
        else if (l_req) state_n = LETTER;
        else if (b_req) state_n = BLINK;
      CLEAR: begin
        x_cnt_n = x_wrap ? '0 : x_cnt + 9'd1;
        y_cnt_n = x_wrap ? y_cnt + 9'd1 : y_cnt;
        if (x_wrap && y_cnt == Y_LAST) state_n = IDLE;
      end
      LETTER:
        if (!l_req) begin
          state_n = IDLE;
          last_n = LETTER;
        end
      BLINK:
        if (!b_req) begin
          state_n = IDLE;
          last_n = BLINK;
        end
    endcase
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      last_owner <= BLINK;
      clr_pending <= 1'b0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      state <= state_n;
      last_owner <= last_n;
      clr_pending <= pending_n;
      x_cnt <= x_cnt_n;
      y_cnt <= y_cnt_n;
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      x <= '0;
      y <= '0;
      color <= '0;
      writeEn <= 1'b0;
    end else begin
      x <= state == CLEAR ? x_cnt : state == LETTER ? l_x : state == BLINK ? b_x : x;
      y <= state == CLEAR ? y_cnt : state == LETTER ? l_y : state == BLINK ? b_y : y;
      color <= state == CLEAR ? CLEAR_COLOR : state == LETTER ? l_color : state == BLINK ? b_color : color;
      writeEn <= state == CLEAR || (state == LETTER && l_en && l_inb) || (state == BLINK && b_en && b_inb);
    end
  end
endmodule
